aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- FSM controller that sequences the shared AES encrypt-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) over one 128-bit block.
- Issues one-hot step enables to the datapath's state register and mux, and requests round keys from the key-schedule block over a req/ack handshake.
- Skips MixColumns in the final round.
- Sits between the block-level in/out handshake and the column datapath; carries no data itself.

Parameters:
- NUM_ROUNDS, 10, total cipher rounds (10/12/14 for AES-128/192/256); legal range 2..14.
- KEY_IDX_W, 4, width of round-key index; must satisfy 2**KEY_IDX_W > NUM_ROUNDS.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  plaintext block present at datapath input.
- in_ready  out  1  sequencer idle, block may be accepted.
- load_in  out  1  pulse: datapath state register captures plaintext.
- sub_en  out  1  pulse: state <= SubBytes(state).
- shift_en  out  1  pulse: state <= ShiftRows(state).
- mix_en  out  1  pulse: state <= MixColumns(state).
- ark_en  out  1  pulse: state <= state ^ round_key.
- key_req  out  1  round key requested.
- key_idx  out  KEY_IDX_W  index of requested round key (0..NUM_ROUNDS).
- key_ack  in  1  round key valid on datapath key input this cycle.
- round_idx  out  KEY_IDX_W  current round number, debug/status.
- out_valid  out  1  ciphertext valid in datapath state register.
- out_ready  in  1  consumer accepts ciphertext.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: async on rst_n low. FSM=IDLE, round_idx=0, key_idx=0. All enables, key_req, out_valid and busy = 0. in_ready=1 one cycle after release (combinational from IDLE).
- States: IDLE, ARK0, SUB, SHIFT, MIX, ARK, DONE.
- Enable outputs are combinational from state (plus key_ack for ark_en). At most one of load_in/sub_en/shift_en/mix_en/ark_en is high in any cycle.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready: load_in=1 in the same cycle, round_idx<=0, go to ARK0.
- ARK0 and ARK:
  - key_req=1, key_idx=round_idx.
  - key_idx stays stable and key_req stays high until key_ack.
  - ark_en = key_ack (same cycle). No transition without key_ack.
- ARK0 + key_ack: round_idx<=1, go to SUB.
- SUB: sub_en=1, go to SHIFT.
- SHIFT: shift_en=1.
  - round_idx==NUM_ROUNDS: go to ARK.
  - Otherwise: go to MIX.
- MIX: mix_en=1, go to ARK.
- ARK + key_ack:
  - round_idx==NUM_ROUNDS: go to DONE.
  - Otherwise: round_idx<=round_idx+1, go to SUB.
- DONE:
  - out_valid=1, held until out_ready.
  - out_ready: go to IDLE.
  - in_ready=0 in DONE; no back-to-back accept in the same cycle.
- Latency with key_ack always high: accept at cycle T, out_valid first at T+4*NUM_ROUNDS+1 (T+41 for NUM_ROUNDS=10). Each key_ack stall cycle adds 1.
- round_idx never exceeds NUM_ROUNDS and never wraps.
- key_ack outside ARK0/ARK is ignored. in_valid outside IDLE is ignored.
- Reset asserted mid-operation: immediately to IDLE, outputs as at reset. Datapath contents are don't-care.

Optional Feature:
- AES_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort high in any non-IDLE state: no enable or key_req is asserted that cycle, FSM goes to IDLE next cycle, round_idx<=0, out_valid drops.
  - abort has priority over key_ack and out_ready.
  - abort in IDLE has no effect.
- AES_ABORT_EN undefined: port absent; behaviour as above.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - FSM state enum aes_seq_state_t.
  - Constant AES128_ROUNDS=10.
  - Helper function last_round(idx, n).
- Round-key index type stays local, since it is parameter-dependent.
- One natural sub-module, aes_round_ctr: round counter with clear, increment and last-round flag. Its output drives round_idx and key_idx.

Test Plan:
- Reset then single block, key_ack tied 1, out_ready tied 1:
  - load_in at T, out_valid at T+41.
  - Exactly 10 sub_en, 10 shift_en, 9 mix_en, 11 ark_en.
  - key_idx sequence 0..10.
- Final round: no mix_en between shift_en for round 10 and ark_en for key_idx=10. FIPS-197 Appendix B vector through the full datapath gives ciphertext 3925841d02dc09fbdc118597196a0b32.
- key_ack delayed 3 cycles on round 5: key_req and key_idx=5 held stable for 3 cycles, ark_en only in the ack cycle, out_valid at T+44.
- out_ready low 5 cycles in DONE: out_valid held 5 cycles, in_ready=0, a new in_valid is not accepted. After out_ready, IDLE with in_ready=1.
- rst_n low during round 4 MIX: all outputs 0 asynchronously, busy=0. After release, a new block runs to correct completion.
- AES_ABORT_EN: abort at round 3 SUB gives no sub_en that cycle, IDLE next cycle, and round_idx=0.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES round sequencer slice.
// Optional abort port is enabled by defining AES_ABORT_EN.
package aes_ctrl_pkg;

  localparam int unsigned AES128_ROUNDS = 10;

  typedef enum logic [2:0] {
    StIdle,
    StArk0,
    StSub,
    StShift,
    StMix,
    StArk,
    StDone
  } aes_seq_state_t;

  function automatic logic last_round(input int unsigned idx, input int unsigned n);
    return idx == n;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Handshake and step-enable bundle between the sequencer, block I/O, datapath and key schedule.
// Defining AES_ABORT_EN adds the abort request.
interface aes_round_sequencer_if #(
  parameter int unsigned KEY_IDX_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 load_in;
  logic                 sub_en;
  logic                 shift_en;
  logic                 mix_en;
  logic                 ark_en;
  logic                 key_req;
  logic [KEY_IDX_W-1:0] key_idx;
  logic                 key_ack;
  logic [KEY_IDX_W-1:0] round_idx;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
`ifdef AES_ABORT_EN
  logic                 abort;
`endif

  modport master (
    input  in_valid, key_ack, out_ready,
`ifdef AES_ABORT_EN
    input  abort,
`endif
    output in_ready, load_in, sub_en, shift_en, mix_en, ark_en, key_req, key_idx,
    output round_idx, out_valid, busy
  );

  modport slave (
    output in_valid, key_ack, out_ready,
`ifdef AES_ABORT_EN
    output abort,
`endif
    input  in_ready, load_in, sub_en, shift_en, mix_en, ark_en, key_req, key_idx,
    input  round_idx, out_valid, busy
  );

endinterface

// File: rtl/aes_round_ctr.sv
// Round counter: clear, saturating increment and a last-round flag.
module aes_round_ctr
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NumRounds = AES128_ROUNDS,
  parameter int unsigned IdxW      = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [IdxW-1:0] idx_o,
  output logic            last_o
);

  logic [IdxW-1:0] idx_q, idx_d;

  assign idx_o  = idx_q;
  assign last_o = last_round(32'(idx_q), NumRounds);

  // Increment is blocked on the last round so the index can never wrap.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i && !last_o) begin
      idx_d = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Step sequencer for the shared AES encrypt-round datapath; carries no data itself.
// Defining AES_ABORT_EN adds an abort input that returns the FSM to idle.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
  parameter int unsigned KEY_IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_round_sequencer_if.master bus
);

  aes_seq_state_t state_q, state_d;

  logic                 ctr_clr;
  logic                 ctr_inc;
  logic                 ctr_last;
  logic [KEY_IDX_W-1:0] ctr_idx;
  logic                 abort_act;

  logic in_ready, load_in, sub_en, shift_en, mix_en, ark_en, key_req, out_valid, busy;

`ifdef AES_ABORT_EN
  assign abort_act = bus.abort && (state_q != StIdle);
`else
  assign abort_act = 1'b0;
`endif

  aes_round_ctr #(
    .NumRounds (NUM_ROUNDS),
    .IdxW      (KEY_IDX_W)
  ) u_round_ctr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (ctr_clr),
    .inc_i  (ctr_inc),
    .idx_o  (ctr_idx),
    .last_o (ctr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_clr = 1'b0;
    ctr_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StArk0;
          ctr_clr = 1'b1;
        end
      end
      StArk0: begin
        if (bus.key_ack) begin
          state_d = StSub;
          ctr_inc = 1'b1;
        end
      end
      StSub:   state_d = StShift;
      // Final round skips MixColumns.
      StShift: state_d = ctr_last ? StArk : StMix;
      StMix:   state_d = StArk;
      StArk: begin
        if (bus.key_ack) begin
          if (ctr_last) begin
            state_d = StDone;
          end else begin
            state_d = StSub;
            ctr_inc = 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_act) begin
      state_d = StIdle;
      ctr_clr = 1'b1;
      ctr_inc = 1'b0;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    load_in   = 1'b0;
    sub_en    = 1'b0;
    shift_en  = 1'b0;
    mix_en    = 1'b0;
    ark_en    = 1'b0;
    key_req   = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  load_in = bus.in_valid;
      StArk0, StArk: begin
        key_req = 1'b1;
        ark_en  = bus.key_ack;
      end
      StSub:   sub_en    = 1'b1;
      StShift: shift_en  = 1'b1;
      StMix:   mix_en    = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
    if (abort_act) begin
      sub_en   = 1'b0;
      shift_en = 1'b0;
      mix_en   = 1'b0;
      ark_en   = 1'b0;
      key_req  = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.load_in   = load_in;
  assign bus.sub_en    = sub_en;
  assign bus.shift_en  = shift_en;
  assign bus.mix_en    = mix_en;
  assign bus.ark_en    = ark_en;
  assign bus.key_req   = key_req;
  assign bus.key_idx   = ctr_idx;
  assign bus.round_idx = ctr_idx;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: drives the sequencer, models the AES datapath and key store from its enables,
// and checks timing, step counts and the FIPS-197 Appendix B ciphertext.
module tb_aes_round_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  aes_round_sequencer_if #(.KEY_IDX_W(4)) bus ();

  aes_round_sequencer #(
    .NUM_ROUNDS (10),
    .KEY_IDX_W  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0]  r = 8'h01;
    logic [7:0]  x = b;
    logic [7:0]  e = 8'd254;
    logic [15:0] t;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gm(r, x);
      x = gm(x, x);
    end
    t = {r, r};
    return r ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
      r[103-32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
    end
    return r;
  endfunction

  logic [127:0] rk [0:15];
  logic [127:0] st;

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 16; i++) rk[i] = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Behavioural datapath steered only by the sequencer's enables.
  always @(posedge clk) begin
    if (bus.load_in)       st <= 128'h3243f6a8885a308d313198a2e0370734;
    else if (bus.sub_en)   st <= sub_bytes(st);
    else if (bus.shift_en) st <= shift_rows(st);
    else if (bus.mix_en)   st <= mix_columns(st);
    else if (bus.ark_en)   st <= st ^ rk[bus.key_idx];
  end

  // ---------------- monitor ----------------
  int n_load, n_sub, n_shift, n_mix, n_ark, n_multi, n_mix_final, n_stall5, n_ark_noack;
  int t_load, t_out;
  bit got_out, final_shift;
  int keys[$];
  logic [127:0] ct;

  always @(negedge clk) begin
    if (rst_n) begin
      n_load  += int'(bus.load_in);
      n_sub   += int'(bus.sub_en);
      n_shift += int'(bus.shift_en);
      n_mix   += int'(bus.mix_en);
      n_ark   += int'(bus.ark_en);
      if ($countones({bus.load_in, bus.sub_en, bus.shift_en, bus.mix_en, bus.ark_en}) > 1)
        n_multi++;
      if (bus.ark_en) keys.push_back(int'(bus.key_idx));
      if (bus.ark_en && !bus.key_ack) n_ark_noack++;
      if (bus.shift_en && bus.round_idx == 4'd10) final_shift = 1'b1;
      if (bus.mix_en && final_shift) n_mix_final++;
      if (bus.key_req && !bus.key_ack && bus.key_idx == 4'd5) n_stall5++;
      if (bus.load_in) t_load = cyc;
      if (bus.out_valid && !got_out) begin
        got_out = 1'b1;
        t_out   = cyc;
        ct      = st;
      end
    end
  end

  task automatic clear_mon();
    n_load = 0; n_sub = 0; n_shift = 0; n_mix = 0; n_ark = 0; n_multi = 0;
    n_mix_final = 0; n_stall5 = 0; n_ark_noack = 0;
    t_load = 0; t_out = 0; got_out = 1'b0; final_shift = 1'b0;
    keys.delete();
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block();
    clear_mon();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 100 && !bus.out_valid; i++) step();
    check({tag, "_out_valid_seen"}, 128'(bus.out_valid), 128'd1);
  endtask

  localparam logic [127:0] Ct = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    clear_mon();
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.key_ack   = 1'b1;
    bus.out_ready = 1'b1;
`ifdef AES_ABORT_EN
    bus.abort     = 1'b0;
`endif

    // Reset state.
    #12;
    check("reset_outputs", 128'({bus.load_in, bus.sub_en, bus.shift_en, bus.mix_en, bus.ark_en,
                                 bus.key_req, bus.out_valid, bus.busy, bus.round_idx,
                                 bus.key_idx}), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", 128'(bus.in_ready), 128'd1);
    check("busy_after_reset", 128'(bus.busy), 128'd0);

    // Single block, key_ack and out_ready tied high.
    start_block();
    wait_out("blk1");
    step();
    checki("blk1_latency", t_out - t_load, 41);
    checki("blk1_load", n_load, 1);
    checki("blk1_sub", n_sub, 10);
    checki("blk1_shift", n_shift, 10);
    checki("blk1_mix", n_mix, 9);
    checki("blk1_ark", n_ark, 11);
    checki("blk1_onehot", n_multi, 0);
    checki("blk1_no_final_mix", n_mix_final, 0);
    checki("blk1_key_count", keys.size(), 11);
    for (int i = 0; i < 11 && i < keys.size(); i++) checki("blk1_key_idx", keys[i], i);
    check("blk1_ciphertext", ct, Ct);
    check("blk1_idle_in_ready", 128'(bus.in_ready), 128'd1);

    // key_ack withheld three cycles in round 5.
    start_block();
    for (int i = 0; i < 60 && !(bus.key_req && bus.key_idx == 4'd5); i++) step();
    check("stall_reached_key5", 128'({bus.key_req, bus.key_idx}), 128'h15);
    bus.key_ack = 1'b0;
    step();
    step();
    step();
    check("stall_req_held", 128'({bus.key_req, bus.key_idx, bus.ark_en}), 128'h2a);
    bus.key_ack = 1'b1;
    wait_out("stall");
    step();
    checki("stall_cycles", n_stall5, 3);
    checki("stall_ark_noack", n_ark_noack, 0);
    checki("stall_ark", n_ark, 11);
    checki("stall_latency", t_out - t_load, 44);
    check("stall_ciphertext", ct, Ct);

    // Consumer holds off for five cycles while a new block is offered.
    bus.out_ready = 1'b0;
    clear_mon();
    bus.in_valid = 1'b1;
    step();
    wait_out("hold");
    for (int i = 0; i < 5; i++) begin
      check("hold_state", 128'({bus.out_valid, bus.in_ready, bus.load_in, bus.busy}), 128'b1001);
      if (i < 4) step();
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    step();
    check("hold_released", 128'({bus.in_ready, bus.busy, bus.out_valid}), 128'b100);
    checki("hold_single_load", n_load, 1);
    check("hold_ciphertext", ct, Ct);

    // Asynchronous reset during round 4 MixColumns, then a clean block.
    start_block();
    for (int i = 0; i < 60 && !(bus.mix_en && bus.round_idx == 4'd4); i++) step();
    check("rst_reached_r4_mix", 128'({bus.mix_en, bus.round_idx}), 128'h14);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 128'({bus.load_in, bus.sub_en, bus.shift_en, bus.mix_en, bus.ark_en,
                                   bus.key_req, bus.out_valid, bus.busy, bus.round_idx,
                                   bus.key_idx}), 128'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_mid_in_ready", 128'(bus.in_ready), 128'd1);
    start_block();
    wait_out("post_rst");
    step();
    checki("post_rst_latency", t_out - t_load, 41);
    check("post_rst_ciphertext", ct, Ct);

`ifdef AES_ABORT_EN
    // Abort in round 3 SubBytes.
    start_block();
    for (int i = 0; i < 60 && !(bus.sub_en && bus.round_idx == 4'd3); i++) step();
    check("abort_reached_r3_sub", 128'({bus.sub_en, bus.round_idx}), 128'h13);
    bus.abort = 1'b1;
    #1;
    check("abort_gates_enables", 128'({bus.sub_en, bus.key_req, bus.busy}), 128'b001);
    step();
    bus.abort = 1'b0;
    check("abort_idle", 128'({bus.in_ready, bus.busy, bus.round_idx}), 128'h20);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
